pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, IMEM wait, fetch watchdog
// Optional macro HAZ_PERF_CNT_EN adds stall_cycles / flush_count performance counters.
module pipe_hazard_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       imem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       fetch_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {RUN, IMEM_WAIT, REDIRECT} state_t;

  state_t     state, next_state;
  logic [7:0] wait_cnt;
  logic       load_use;
  logic       br_flush;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Defaults are the reset-time values so the outputs follow reset asynchronously.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
    br_flush    = 1'b0;
    next_state  = state;
    if (!reset) begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            pc_en    = 1'b1;
            br_flush = 1'b1;
          end else if (load_use) begin
            if_id_flush = 1'b0;
          end else if (!imem_ready) begin
            id_ex_flush = 1'b0;
            next_state  = IMEM_WAIT;
          end else begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
          end
        end
        IMEM_WAIT: begin
          if (ex_branch_taken) begin
            pc_en      = 1'b1;
            br_flush   = 1'b1;
            next_state = REDIRECT;
          end else if (imem_ready) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            next_state  = RUN;
          end else begin
            id_ex_flush = 1'b0;
          end
        end
        default: begin
          // REDIRECT: the returning word belongs to the old path and is discarded.
          id_ex_flush = ex_branch_taken;
          br_flush    = ex_branch_taken;
          if (imem_ready) next_state = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      wait_cnt      <= 8'd0;
      fetch_timeout <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == RUN)
        wait_cnt <= 8'd0;
      else if (state != RUN && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
      if (wait_cnt == TIMEOUT)
        fetch_timeout <= 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_count  <= 16'd0;
    end else begin
      if (!pc_en)
        stall_cycles <= stall_cycles + 32'd1;
      if (br_flush && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule
